// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: single-outstanding instruction prefetcher feeding a DEPTH-entry queue to the decoder.
module instr_fetch_queue #(
   parameter int BUS_WIDTH = 33,
   parameter int PC_WIDTH  = 16,
   parameter int DEPTH     = 4,
   parameter int RESET_PC  = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 flush,
   input  logic [PC_WIDTH-1:0]  flush_pc,
   output logic                 imem_req,
   output logic [PC_WIDTH-1:0]  imem_addr,
   input  logic                 imem_ack,
   input  logic [BUS_WIDTH-1:0] imem_rdata,
   output logic                 instr_valid,
   output logic [BUS_WIDTH-1:0] instr,
   input  logic                 next_instr,
   output logic [PC_WIDTH-1:0]  fetch_pc
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   localparam logic [PC_WIDTH-1:0] RPC = PC_WIDTH'(RESET_PC);
   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;
   state_t state_q, state_d;
   logic [AW:0] count_q;
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [PC_WIDTH-1:0] pc_q, addr_q;
   logic [BUS_WIDTH-1:0] mem_data [DEPTH];
   logic [PC_WIDTH-1:0] mem_pc [DEPTH];
   logic push, pop;
   always_comb begin
      state_d = state_q;
      if (state_q == IDLE) state_d = (!flush && count_q < FULL) ? WAIT : IDLE;
      else if (imem_ack) state_d = IDLE;
      else if (flush) state_d = DRAIN;
   end
   assign push        = state_q == WAIT && imem_ack && !flush;
   assign pop         = next_instr && instr_valid && !flush;
   assign imem_req    = state_q != IDLE;
   assign imem_addr   = addr_q;
   assign instr_valid = count_q != '0;
   // Empty queue presents zeros so unreset storage never leaks to the decoder.
   assign instr       = instr_valid ? mem_data[rd_ptr] : '0;
   assign fetch_pc    = instr_valid ? mem_pc[rd_ptr] : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         count_q <= '0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         pc_q    <= RPC;
         addr_q  <= RPC;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && state_d == WAIT) addr_q <= pc_q;
         if (flush) begin
            count_q <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            pc_q    <= flush_pc;
         end else begin
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (push) pc_q <= pc_q + PC_WIDTH'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
         end
      end
   end
   always_ff @(posedge clk) begin
      if (push) begin
         mem_data[wr_ptr] <= imem_rdata;
         mem_pc[wr_ptr]   <= addr_q;
      end
   end
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_instr_fetch_queue;
   localparam int BW = 33, PW = 16, DEPTH = 4;
   logic clk = 0, rst_n = 0, flush = 0, imem_ack = 0, next_instr = 0;
   logic [PW-1:0] flush_pc = '0, imem_addr, fetch_pc;
   logic [BW-1:0] imem_rdata = '0, instr;
   logic imem_req, instr_valid;
   int tests = 0, fails = 0;
   typedef struct {logic [PW-1:0] pc; logic [BW-1:0] d;} ent_t;
   ent_t mq[$];
   logic [PW-1:0] m_pc, m_addr;
   bit m_out, m_drop;

   instr_fetch_queue #(.BUS_WIDTH(BW), .PC_WIDTH(PW), .DEPTH(DEPTH), .RESET_PC(0)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .flush_pc(flush_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .next_instr(next_instr), .fetch_pc(fetch_pc));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference: one outstanding fetch, plain FIFO of fetched words, flush discards everything.
   task automatic model_update();
      int pre = mq.size();
      bit issue = !m_out && !flush && pre < DEPTH;
      if (flush) begin
         mq.delete();
         m_pc = flush_pc;
         if (m_out) begin
            if (imem_ack) m_out = 0;
            else m_drop = 1;
         end
      end else begin
         if (next_instr && pre != 0) void'(mq.pop_front());
         if (m_out && imem_ack) begin
            if (!m_drop) begin
               mq.push_back('{m_addr, imem_rdata});
               m_pc = m_pc + 1'b1;
            end
            m_out = 0;
         end
      end
      if (issue) begin
         m_out = 1;
         m_drop = 0;
         m_addr = m_pc;
      end
   endtask

   task automatic check_outputs();
      chk("valid", instr_valid, mq.size() != 0);
      if (mq.size() != 0) begin
         chk("instr", instr, mq[0].d);
         chk("fetch_pc", fetch_pc, mq[0].pc);
      end
      chk("req", imem_req, m_out);
      if (m_out) chk("addr", imem_addr, m_addr);
   endtask

   task automatic step(input logic fl, input logic [PW-1:0] fpc, input logic nx, input logic ak, input logic [BW-1:0] d);
      flush = fl;
      flush_pc = fpc;
      next_instr = nx;
      imem_ack = ak & imem_req;
      imem_rdata = d;
      @(posedge clk);
      model_update();
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      #3 rst_n = 0;
      imem_ack = 1;
      imem_rdata = '1;
      flush = 0;
      next_instr = 0;
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_fpc", fetch_pc, 0);
      chk("rst_addr", imem_addr, 0);
      @(negedge clk);
      chk("rst_hold_req", imem_req, 0);
      rst_n = 1;
      imem_ack = 0;
      mq.delete();
      m_pc = 0;
      m_addr = 0;
      m_out = 0;
      m_drop = 0;
   endtask

   initial begin
      @(negedge clk);
      do_reset();
      for (int i = 0; i < 12; i++) step(0, 0, 0, 1, BW'(33'h100 + i));
      chk("full_req", imem_req, 0);
      chk("full_fpc", fetch_pc, 0);
      step(0, 0, 1, 0, 0);
      chk("adv_fpc", fetch_pc, 1);
      step(0, 0, 0, 0, 0);
      chk("refill_req", imem_req, 1);
      chk("refill_addr", imem_addr, 4);
      step(0, 0, 0, 1, 33'h0_1234_5678);
      step(1, 16'h0000, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 33'h1_DEAD_BEEF);
      chk("beef_valid", instr_valid, 1);
      chk("beef_instr", instr, 33'h1_DEAD_BEEF);
      chk("beef_fpc", fetch_pc, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 33'h0_0000_AAAA);
      chk("swap_fpc", fetch_pc, 1);
      chk("swap_instr", instr, 33'h0_0000_AAAA);
      step(0, 0, 1, 0, 0);
      step(0, 0, 1, 0, 0);
      chk("empty_valid", instr_valid, 0);
      step(1, 16'h0100, 0, 0, 0);
      chk("drain_req", imem_req, 1);
      chk("drain_addr", imem_addr, 2);
      step(0, 0, 0, 0, 0);
      step(0, 0, 1, 1, 33'h0_0BAD_0BAD);
      chk("drop_valid", instr_valid, 0);
      step(0, 0, 0, 0, 0);
      chk("redir_addr", imem_addr, 16'h0100);
      do_reset();
      step(0, 0, 0, 0, 0);
      chk("restart_req", imem_req, 1);
      chk("restart_addr", imem_addr, 0);
      for (int i = 0; i < 2000; i++) begin
         if (i % 700 == 699) do_reset();
         step($urandom % 20 == 0, PW'($urandom), $urandom % 3 == 0, $urandom % 3 != 0,
              {1'($urandom), 32'($urandom)});
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 33, instruction word width (matches decoder instruction bus).
REQ-002 SHALL have parameter PC_WIDTH, default 16, word-address width of instruction memory.
REQ-003 SHALL have parameter DEPTH, default 4, queue entries; power of two, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0, first fetch address after reset.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-007 SHALL have port flush  input  1  discard queued/in-flight instructions, redirect fetch.
REQ-008 SHALL have port flush_pc  input  PC_WIDTH  redirect word address, sampled when flush=1.
REQ-009 SHALL have port imem_req  output  1  memory read request.
REQ-010 SHALL have port imem_addr  output  PC_WIDTH  memory read word address.
REQ-011 SHALL have port imem_ack  input  1  read data valid; completes the request.
REQ-012 SHALL have port imem_rdata  input  BUS_WIDTH  read data, valid when imem_ack=1.
REQ-013 SHALL have port instr_valid  output  1  queue head valid, to decoder.
REQ-014 SHALL have port instr  output  BUS_WIDTH  queue head instruction, to decoder.
REQ-015 SHALL have port next_instr  input  1  decoder consumes head this cycle.
REQ-016 SHALL have port fetch_pc  output  PC_WIDTH  word address of current head entry.

Function
REQ-017 SHALL keep at most one memory request outstanding.
REQ-018 SHALL assert imem_req when idle, not flushing, and count + 1 <= DEPTH; imem_addr=pc.
REQ-019 SHALL hold imem_req and imem_addr stable from assertion until the imem_ack cycle inclusive.
REQ-020 SHALL treat an ack cycle as request complete; a new request may assert on the following cycle.
REQ-021 SHALL write imem_rdata and imem_addr at the tail on ack (unless discarding), and increment pc by 1, wrapping modulo 2^PC_WIDTH.
REQ-022 SHALL drive instr_valid=1 iff count!=0; instr and fetch_pc SHALL be head-entry register values (no combinational path from imem_rdata).
REQ-023 SHALL pop head on a cycle with next_instr=1 and instr_valid=1; next_instr while empty SHALL be ignored.
REQ-024 SHALL leave count unchanged on a simultaneous push and pop; a push while full SHALL be impossible by REQ-018.
REQ-025 SHALL wrap read/write pointers modulo DEPTH; count ranges 0..DEPTH.
REQ-026 SHALL implement FSM IDLE (no request), WAIT (request outstanding), DRAIN (outstanding request to be discarded).
REQ-027 SHALL transition IDLE->WAIT when REQ-018 holds; WAIT->IDLE on ack; WAIT->DRAIN on flush without ack; DRAIN->IDLE on ack.
REQ-028 SHALL on flush clear count and pointers, load pc=flush_pc, and drop any ack data in that cycle or during DRAIN.
REQ-029 SHALL give flush priority over same-cycle next_instr and ack; instr_valid=0 the cycle after flush.
REQ-030 SHALL not issue a new request in the flush cycle; first post-flush request asserts the next cycle from IDLE with imem_addr=flush_pc.
REQ-031 SHALL hold imem_req asserted in DRAIN with the original address until ack.
REQ-032 SHALL have latency: ack in cycle N, instr_valid=1 with that data in cycle N+1 when queue was empty.

Reset
REQ-033 SHALL on rst_n=0 asynchronously force state IDLE, count=0, pointers 0, pc=RESET_PC, imem_req=0, instr_valid=0.
REQ-034 SHALL reset imem_addr=RESET_PC, instr=0, fetch_pc=0; queue storage need not reset.
REQ-035 SHALL assert imem_req first rising edge after rst_n release, address RESET_PC.
REQ-036 SHALL abandon an in-flight request on reset; acks arriving while rst_n=0 SHALL be ignored.

Verification
REQ-037 Reset release, ack every 2nd cycle, next_instr=0 -> addresses 0,1,2,3 fetched, then imem_req=0 with count=4.
REQ-038 Full queue, next_instr pulse one cycle -> head advances to word 1, one new request with addr 4.
REQ-039 Ack on cycle N into empty queue with imem_rdata=0x1_DEAD_BEEF -> cycle N+1 instr_valid=1, instr=0x1_DEAD_BEEF, fetch_pc=0.
REQ-040 Flush with flush_pc=0x0100 while request outstanding to addr 5 -> DRAIN, ack data dropped, next request addr 0x0100, instr_valid=0 until its ack.
REQ-041 Count=1 with simultaneous ack and next_instr -> count stays 1, head is new data; next_instr while empty -> no state change.
REQ-042 rst_n low mid-WAIT with imem_ack pulsed during reset -> all outputs reset values, restart at RESET_PC after release.
